// File: rtl/winograd_product_accumulator.sv
// Accumulates a programmed run of signed multiplier products into a wide sum.
// Define WINOGRAD_ACC_SATURATION_EN to clamp on overflow instead of wrapping.
module winograd_product_accumulator #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] remaining;
    logic             ovf;

    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] raw_sum;
    logic [ACC_W-1:0] acc_next;
    logic             add_ovf;

    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    always_comb begin
        ext      = ACC_W'($signed(in_prod));
        raw_sum  = acc + ext;
        add_ovf  = (acc[ACC_W-1] == ext[ACC_W-1]) &&
                   (raw_sum[ACC_W-1] != acc[ACC_W-1]);
        acc_next = raw_sum;
`ifdef WINOGRAD_ACC_SATURATION_EN
        // Clamp toward the side both operands were on.
        if (add_ovf) begin
            acc_next = ext[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            remaining <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc       <= '0;
                        count     <= '0;
                        ovf       <= 1'b0;
                        remaining <= len;
                        busy      <= 1'b1;
                        if (len == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state    <= ACC;
                            in_ready <= 1'b1;
                        end
                    end
                end
                ACC: begin
                    if (in_valid && in_ready) begin
                        acc       <= acc_next;
                        ovf       <= ovf | add_ovf;
                        count     <= count + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == CNT_W'(1)) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign out_sum   = acc;
    assign out_count = count;
    assign out_ovf   = ovf;

endmodule
